// File: rtl/framebuffer_pkg.sv
// Shared types and helpers for the multi-group framebuffer pixel fetcher.
package framebuffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_t;

  function automatic int unsigned addr_width(input int unsigned pw, input int unsigned ph,
                                             input int unsigned ng);
    return 1 + $clog2(ng) + $clog2(ph) + $clog2(pw);
  endfunction

  function automatic int unsigned pixel_bus_width(input int unsigned bpp, input int unsigned ng);
    return ng * bpp * 8;
  endfunction

  // Packs {frame, group, row, col}; each field is masked to its width so no carry crosses fields.
  function automatic logic [63:0] pack_addr(input logic frame, input int unsigned grp,
                                            input int unsigned row, input int unsigned col,
                                            input int unsigned gw, input int unsigned rw,
                                            input int unsigned cw);
    logic [63:0] a;
    a = 64'(frame);
    a = (a << gw) | (64'(grp) & ((64'd1 << gw) - 64'd1));
    a = (a << rw) | (64'(row) & ((64'd1 << rw) - 64'd1));
    a = (a << cw) | (64'(col) & ((64'd1 << cw) - 64'd1));
    return a;
  endfunction

endpackage

// File: rtl/fetch_capture_pipe.sv
// Delays (issue valid, group index) by the RAM read latency to form capture strobes.
module fetch_capture_pipe #(
  parameter int LATENCY = 1,
  parameter int GW      = 1
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          issue_valid,
  input  logic [GW-1:0] issue_group,
  output logic          cap_valid,
  output logic [GW-1:0] cap_group
);

  logic [LATENCY-1:0] valid_sr;
  logic [GW-1:0]      group_sr [LATENCY];

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      valid_sr <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) group_sr[k] <= '0;
    end else begin
      valid_sr[0] <= issue_valid;
      group_sr[0] <= issue_group;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        valid_sr[k] <= valid_sr[k-1];
        group_sr[k] <= group_sr[k-1];
      end
    end
  end

  assign cap_valid = valid_sr[LATENCY-1];
  assign cap_group = group_sr[LATENCY-1];

endmodule

// File: rtl/framebuffer_fetch_multi.sv
// Fetches NUM_GROUPS scan-group pixels for one (row, column) and presents them atomically.
module framebuffer_fetch_multi
  import framebuffer_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 16,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int NUM_GROUPS      = 2,
  parameter int RAM_LATENCY     = 1,
  parameter int MIRROR_COLUMNS  = 1
) (
  input  logic                                                 clk_in,
  input  logic                                                 reset_n,
  input  logic                                                 pixel_load_start,
  input  logic [$clog2(PIXEL_WIDTH)-1:0]                       column_address,
  input  logic [$clog2(PIXEL_HEIGHT)-1:0]                      row_address,
  input  logic                                                 frame_select,
  input  logic [BYTES_PER_PIXEL*8-1:0]                         ram_data_in,
  output logic [addr_width(PIXEL_WIDTH, PIXEL_HEIGHT, NUM_GROUPS)-1:0] ram_address,
  output logic                                                 ram_clk_enable,
  output logic [pixel_bus_width(BYTES_PER_PIXEL, NUM_GROUPS)-1:0] pixel_data,
  output logic                                                 pixel_valid,
  output logic                                                 busy,
  output logic                                                 overrun
);

  localparam int CLW  = $clog2(PIXEL_WIDTH);
  localparam int RW   = $clog2(PIXEL_HEIGHT);
  localparam int GW   = $clog2(NUM_GROUPS);
  localparam int AW   = addr_width(PIXEL_WIDTH, PIXEL_HEIGHT, NUM_GROUPS);
  localparam int DW   = BYTES_PER_PIXEL * 8;
  localparam int CNTW = $clog2(NUM_GROUPS + RAM_LATENCY) + 1;

  fetch_state_t    state, state_next;
  logic [CLW-1:0]  col_l;
  logic [RW-1:0]   row_l;
  logic            frame_l;
  logic [CNTW-1:0] issue_cnt;
  logic            issue_last;
  logic            fin;
  logic [DW-1:0]   staging [NUM_GROUPS];
  logic            cap_valid;
  logic [GW-1:0]   cap_group;

  function automatic logic [CLW-1:0] col_field(input logic [CLW-1:0] c);
    return (MIRROR_COLUMNS != 0) ? ~c : c;
  endfunction

  assign issue_last     = (issue_cnt == CNTW'(NUM_GROUPS - 1));
  assign ram_clk_enable = (state == FETCH);
  assign busy           = (state != IDLE);

  fetch_capture_pipe #(
    .LATENCY (RAM_LATENCY),
    .GW      (GW)
  ) u_pipe (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .issue_valid (state == FETCH),
    .issue_group (issue_cnt[GW-1:0]),
    .cap_valid   (cap_valid),
    .cap_group   (cap_group)
  );

  // DONE covers the drain window until the last capture has landed in staging.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pixel_load_start) state_next = FETCH;
      FETCH:   if (issue_last)       state_next = DONE;
      DONE:    if (fin)              state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      col_l       <= '0;
      row_l       <= '0;
      frame_l     <= 1'b0;
      issue_cnt   <= '0;
      fin         <= 1'b0;
      ram_address <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) staging[g] <= '0;
    end else begin
      state       <= state_next;
      pixel_valid <= 1'b0;
      fin         <= cap_valid && (cap_group == GW'(NUM_GROUPS - 1));
      if (cap_valid) staging[cap_group] <= ram_data_in;
      if (pixel_load_start && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: if (pixel_load_start) begin
          col_l       <= column_address;
          row_l       <= row_address;
          frame_l     <= frame_select;
          issue_cnt   <= '0;
          ram_address <= AW'(pack_addr(frame_select, 0, 32'(row_address),
                                       32'(col_field(column_address)), GW, RW, CLW));
        end
        FETCH: if (!issue_last) begin
          issue_cnt   <= issue_cnt + CNTW'(1);
          ram_address <= AW'(pack_addr(frame_l, 32'(issue_cnt) + 32'd1, 32'(row_l),
                                       32'(col_field(col_l)), GW, RW, CLW));
        end
        DONE: if (fin) begin
          for (int unsigned g = 0; g < NUM_GROUPS; g++) pixel_data[g*DW +: DW] <= staging[g];
          pixel_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_fetch_multi.sv
// Self-checking bench: default instance plus a 4-group, latency-2, unmirrored instance.
module tb_framebuffer_fetch_multi;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        pixel_load_start, start4;
  logic [5:0]  column_address;
  logic [3:0]  row_address;
  logic        frame_select;
  logic [15:0] ram_data, ram4_data, ram4_stage;

  logic [11:0] ram_address;
  logic        ram_clk_enable, pixel_valid, busy, overrun;
  logic [31:0] pixel_data;
  logic [12:0] ram_address4;
  logic        ram_clk_enable4, pixel_valid4, busy4, overrun4;
  logic [63:0] pixel_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  framebuffer_fetch_multi u_dut (
    .clk_in (clk_in), .reset_n (reset_n), .pixel_load_start (pixel_load_start),
    .column_address (column_address), .row_address (row_address),
    .frame_select (frame_select), .ram_data_in (ram_data), .ram_address (ram_address),
    .ram_clk_enable (ram_clk_enable), .pixel_data (pixel_data), .pixel_valid (pixel_valid),
    .busy (busy), .overrun (overrun)
  );

  framebuffer_fetch_multi #(
    .NUM_GROUPS (4), .RAM_LATENCY (2), .MIRROR_COLUMNS (0)
  ) u_dut4 (
    .clk_in (clk_in), .reset_n (reset_n), .pixel_load_start (start4),
    .column_address (column_address), .row_address (row_address),
    .frame_select (frame_select), .ram_data_in (ram4_data), .ram_address (ram_address4),
    .ram_clk_enable (ram_clk_enable4), .pixel_data (pixel_data4), .pixel_valid (pixel_valid4),
    .busy (busy4), .overrun (overrun4)
  );

  function automatic logic [15:0] ram_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // RAM models: data is a fixed function of the address, garbage when not enabled.
  always @(posedge clk_in) ram_data <= ram_clk_enable ? ram_word(16'(ram_address)) : 16'hDEAD;
  always @(posedge clk_in) begin
    ram4_stage <= ram_clk_enable4 ? ram_word(16'(ram_address4)) : 16'hDEAD;
    ram4_data  <= ram4_stage;
  end

  // Reference address for the default instance (mirrored column).
  function automatic int unsigned exp_addr(input int unsigned col, input int unsigned row,
                                           input int unsigned fr, input int unsigned g);
    return fr * 2048 + g * 1024 + row * 64 + (63 - col);
  endfunction

  function automatic logic [31:0] exp_pixels(input int unsigned col, input int unsigned row,
                                             input int unsigned fr);
    return {ram_word(16'(exp_addr(col, row, fr, 1))), ram_word(16'(exp_addr(col, row, fr, 0)))};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // mode 0: plain; mode 1: scramble inputs while busy; mode 2: second start 2 cycles in.
  task automatic run_fetch(input logic [5:0] col, input logic [3:0] row, input logic fr,
                           input int mode, output int lat, output logic [31:0] data,
                           output int naddr, output logic [11:0] a0, output logic [11:0] a1,
                           output int nbusy);
    column_address   = col;
    row_address      = row;
    frame_select     = fr;
    pixel_load_start = 1'b1;
    tick();
    pixel_load_start = 1'b0;
    lat = -1; naddr = 0; nbusy = 0; a0 = '0; a1 = '0; data = '0;
    for (int k = 0; k < 20; k++) begin
      if (ram_clk_enable) begin
        if (naddr == 0) a0 = ram_address;
        else if (naddr == 1) a1 = ram_address;
        naddr++;
      end
      if (pixel_valid) begin
        lat = k;
        data = pixel_data;
        break;
      end
      if (busy) nbusy++;
      if (mode == 1 && k == 1) begin
        column_address = 6'($urandom);
        row_address    = 4'($urandom);
        frame_select   = 1'($urandom);
      end
      if (mode == 2 && k == 2) begin
        column_address   = ~col;
        row_address      = ~row;
        frame_select     = ~fr;
        pixel_load_start = 1'b1;
      end
      tick();
      pixel_load_start = 1'b0;
    end
  endtask

  typedef struct {
    logic [5:0]  col;
    logic [3:0]  row;
    logic        fr;
    logic [11:0] a0;
    logic [11:0] a1;
  } vec_t;

  initial begin
    vec_t        vecs [4];
    int          lat, naddr, nbusy, pv_seen, en_seen, first_issue, last_issue;
    logic [31:0] data, held;
    logic [11:0] a0, a1;
    logic [5:0]  rc;
    logic [3:0]  rr;
    logic        rf;
    logic [63:0] exp4;

    vecs[0] = '{col: 6'd5,  row: 4'd3,  fr: 1'b0, a0: 12'h0FA, a1: 12'h4FA};
    vecs[1] = '{col: 6'd0,  row: 4'd0,  fr: 1'b1, a0: 12'h83F, a1: 12'hC3F};
    vecs[2] = '{col: 6'd63, row: 4'd15, fr: 1'b1, a0: 12'hBC0, a1: 12'hFC0};
    vecs[3] = '{col: 6'd32, row: 4'd8,  fr: 1'b0, a0: 12'h21F, a1: 12'h61F};

    reset_n = 1'b1; pixel_load_start = 1'b0; start4 = 1'b0;
    column_address = '0; row_address = '0; frame_select = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("reset_outputs", {ram_address, ram_clk_enable, pixel_valid, busy, overrun}, '0);
    check("reset_pixel_data", pixel_data, '0);
    check("reset_outputs4", {ram_address4, ram_clk_enable4, pixel_valid4, busy4, overrun4, pixel_data4}, '0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_fetch(vecs[i].col, vecs[i].row, vecs[i].fr, 0, lat, data, naddr, a0, a1, nbusy);
      check($sformatf("vec%0d_addr0", i), a0, vecs[i].a0);
      check($sformatf("vec%0d_addr1", i), a1, vecs[i].a1);
      check($sformatf("vec%0d_naddr", i), naddr, 2);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_busy_cycles", i), nbusy, 4);
      check($sformatf("vec%0d_busy_at_valid", i), busy, 0);
      check($sformatf("vec%0d_data", i), data,
            {ram_word(16'(vecs[i].a1)), ram_word(16'(vecs[i].a0))});
      held = data;
      tick();
      check($sformatf("vec%0d_valid_pulse", i), pixel_valid, 0);
      repeat (3) tick();
      check($sformatf("vec%0d_data_held", i), pixel_data, held);
    end

    // Randomized requests, back-to-back, some with inputs scrambled while busy.
    for (int i = 0; i < 16; i++) begin
      rc = 6'($urandom); rr = 4'($urandom); rf = 1'($urandom);
      run_fetch(rc, rr, rf, int'($urandom_range(0, 1)), lat, data, naddr, a0, a1, nbusy);
      check("rand_addr0", a0, 12'(exp_addr(rc, rr, rf, 0)));
      check("rand_addr1", a1, 12'(exp_addr(rc, rr, rf, 1)));
      check("rand_latency", lat, 4);
      check("rand_data", data, exp_pixels(rc, rr, rf));
    end
    check("no_overrun_b2b", overrun, 0);

    // Second start while busy is ignored and sets sticky overrun.
    run_fetch(6'd10, 4'd2, 1'b1, 2, lat, data, naddr, a0, a1, nbusy);
    check("ovr_latency", lat, 4);
    check("ovr_data", data, exp_pixels(10, 2, 1));
    check("ovr_flag", overrun, 1);
    en_seen = 0; pv_seen = 0;
    repeat (8) begin
      tick();
      if (ram_clk_enable) en_seen++;
      if (pixel_valid) pv_seen++;
    end
    check("ovr_no_second_fetch", {en_seen, pv_seen}, '0);
    check("ovr_sticky", overrun, 1);
    check("ovr_data_held", pixel_data, exp_pixels(10, 2, 1));

    // Reset during the second cycle of a fetch.
    column_address = 6'd7; row_address = 4'd9; frame_select = 1'b1;
    pixel_load_start = 1'b1;
    tick();
    pixel_load_start = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outputs", {ram_address, ram_clk_enable, pixel_valid, busy, overrun}, '0);
    check("midrst_pixel_data", pixel_data, '0);
    pv_seen = 0;
    repeat (3) begin
      tick();
      if (pixel_valid) pv_seen++;
    end
    reset_n = 1'b1;
    repeat (6) begin
      tick();
      if (pixel_valid) pv_seen++;
    end
    check("midrst_no_valid", pv_seen, 0);
    run_fetch(6'd20, 4'd6, 1'b0, 0, lat, data, naddr, a0, a1, nbusy);
    check("post_rst_latency", lat, 4);
    check("post_rst_addr0", a0, 12'(exp_addr(20, 6, 0, 0)));
    check("post_rst_data", data, exp_pixels(20, 6, 0));
    tick();

    // Four groups, latency 2, no mirroring.
    column_address = 6'd0; row_address = 4'd15; frame_select = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    column_address = 6'd33; frame_select = 1'b0;
    lat = -1; naddr = 0; first_issue = -1; last_issue = -1; data = '0;
    for (int k = 0; k < 20; k++) begin
      if (ram_clk_enable4) begin
        check($sformatf("g4_addr%0d", naddr), ram_address4, 13'h13C0 + 13'(naddr) * 13'h0400);
        if (first_issue < 0) first_issue = k;
        last_issue = k;
        naddr++;
      end
      if (pixel_valid4) begin
        lat = k;
        break;
      end
      tick();
    end
    for (int g = 0; g < 4; g++) exp4[g*16 +: 16] = ram_word(16'h13C0 + 16'(g) * 16'h0400);
    check("g4_issue_window", {32'(first_issue), 32'(last_issue)}, {32'd0, 32'd3});
    check("g4_naddr", naddr, 4);
    check("g4_latency", lat, 7);
    check("g4_data", pixel_data4, exp4);
    check("g4_busy_at_valid", busy4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
